// File: rtl/bn_ab_sched.sv
// Channel sequencer for the normalization a/b datapath: reads per-channel
// statistics, drives the a/b calculator and writes coefficients out.
`timescale 1ns/1ps
module bn_ab_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_CH     = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(MAX_CH),
    parameter int unsigned CNT_WIDTH  = $clog2(MAX_CH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         num_ch,
    output logic                         busy,
    output logic                         done,
    output logic                         zero_std_err,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [DATA_WIDTH-1:0] avg_in,
    input  logic signed [DATA_WIDTH-1:0] std_in,
    input  logic signed [DATA_WIDTH-1:0] gamma_in,
    input  logic signed [DATA_WIDTH-1:0] beta_in,
    output logic                         cal_valid,
    output logic signed [DATA_WIDTH-1:0] cal_avg,
    output logic signed [DATA_WIDTH-1:0] cal_std,
    output logic signed [DATA_WIDTH-1:0] cal_gamma,
    output logic signed [DATA_WIDTH-1:0] cal_beta,
    input  logic signed [DATA_WIDTH-1:0] cal_a,
    input  logic signed [DATA_WIDTH-1:0] cal_b,
    input  logic                         cal_valid_out,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic signed [DATA_WIDTH-1:0] wr_a,
    output logic signed [DATA_WIDTH-1:0] wr_b
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        ch_q, ch_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;
    logic                         zse_q, zse_d;
    logic signed [DATA_WIDTH-1:0] cal_avg_q, cal_avg_d;
    logic signed [DATA_WIDTH-1:0] cal_std_q, cal_std_d;
    logic signed [DATA_WIDTH-1:0] cal_gamma_q, cal_gamma_d;
    logic signed [DATA_WIDTH-1:0] cal_beta_q, cal_beta_d;
    logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
    logic signed [DATA_WIDTH-1:0] wr_a_q, wr_a_d;
    logic signed [DATA_WIDTH-1:0] wr_b_q, wr_b_d;
    logic                         last_ch;

    assign last_ch = (CNT_WIDTH'(ch_q) == count_q - CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            count_q     <= '0;
            zse_q       <= 1'b0;
            cal_avg_q   <= '0;
            cal_std_q   <= '0;
            cal_gamma_q <= '0;
            cal_beta_q  <= '0;
            wr_addr_q   <= '0;
            wr_a_q      <= '0;
            wr_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            count_q     <= count_d;
            zse_q       <= zse_d;
            cal_avg_q   <= cal_avg_d;
            cal_std_q   <= cal_std_d;
            cal_gamma_q <= cal_gamma_d;
            cal_beta_q  <= cal_beta_d;
            wr_addr_q   <= wr_addr_d;
            wr_a_q      <= wr_a_d;
            wr_b_q      <= wr_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        count_d     = count_q;
        zse_d       = zse_q;
        cal_avg_d   = cal_avg_q;
        cal_std_d   = cal_std_q;
        cal_gamma_d = cal_gamma_q;
        cal_beta_d  = cal_beta_q;
        wr_addr_d   = wr_addr_q;
        wr_a_d      = wr_a_q;
        wr_b_d      = wr_b_q;
        // Abort freezes every register except state, so the sticky flag survives.
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        zse_d = 1'b0;
                        ch_d  = '0;
                        if (num_ch == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_READ;
                            count_d = (num_ch > CNT_WIDTH'(MAX_CH)) ? CNT_WIDTH'(MAX_CH) : num_ch;
                        end
                    end
                end
                S_READ: state_d = S_LOAD;
                S_LOAD: begin
                    cal_avg_d   = avg_in;
                    cal_gamma_d = gamma_in;
                    cal_beta_d  = beta_in;
                    if (std_in == '0) begin
                        cal_std_d = DATA_WIDTH'(1);
                        zse_d     = 1'b1;
                    end else begin
                        cal_std_d = std_in;
                    end
                    state_d = S_CALC;
                end
                S_CALC: begin
                    wr_addr_d = ch_q;
                    if (cal_valid_out) begin
                        wr_a_d = cal_a;
                        wr_b_d = cal_b;
                    end else begin
                        wr_a_d = '0;
                        wr_b_d = '0;
                        zse_d  = 1'b1;
                    end
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (last_ch) begin
                            state_d = S_DONE;
                        end else begin
                            ch_d    = ch_q + ADDR_WIDTH'(1);
                            state_d = S_READ;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign rd_en        = (state_q == S_READ);
    assign cal_valid    = (state_q == S_CALC);
    assign wr_valid     = (state_q == S_WRITE);
    assign rd_addr      = ch_q;
    assign zero_std_err = zse_q;
    assign cal_avg      = cal_avg_q;
    assign cal_std      = cal_std_q;
    assign cal_gamma    = cal_gamma_q;
    assign cal_beta     = cal_beta_q;
    assign wr_addr      = wr_addr_q;
    assign wr_a         = wr_a_q;
    assign wr_b         = wr_b_q;

endmodule

// File: tb/tb_bn_ab_sched.sv
// Scoreboard bench for bn_ab_sched: directed passes with hand-computed
// coefficients; a negedge monitor checks every accepted write.
`timescale 1ns/1ps
module tb_bn_ab_sched;
    localparam int DW = 16;
    localparam int MC = 64;
    localparam int AW = 6;
    localparam int CW = 7;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0] num_ch = '0;
    logic busy, done, zero_std_err, rd_en, cal_valid, cal_valid_out, wr_valid;
    logic wr_ready = 1'b1;
    logic [AW-1:0] rd_addr, wr_addr;
    logic signed [DW-1:0] avg_in = '0, std_in = '0, gamma_in = '0, beta_in = '0;
    logic signed [DW-1:0] cal_avg, cal_std, cal_gamma, cal_beta, cal_a, cal_b, wr_a, wr_b;

    logic signed [DW-1:0] avg_mem [MC];
    logic signed [DW-1:0] std_mem [MC];
    logic signed [DW-1:0] gam_mem [MC];
    logic signed [DW-1:0] bet_mem [MC];

    typedef struct { int addr; int a; int b; } exp_t;
    exp_t sb [$];

    int tests = 0, fails = 0, wr_count = 0, done_count = 0, last_addr = -1;

    bn_ab_sched #(.DATA_WIDTH(DW), .MAX_CH(MC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_ch(num_ch),
        .busy(busy), .done(done), .zero_std_err(zero_std_err),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .avg_in(avg_in), .std_in(std_in), .gamma_in(gamma_in), .beta_in(beta_in),
        .cal_valid(cal_valid), .cal_avg(cal_avg), .cal_std(cal_std),
        .cal_gamma(cal_gamma), .cal_beta(cal_beta),
        .cal_a(cal_a), .cal_b(cal_b), .cal_valid_out(cal_valid_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b)
    );

    always #5 clk = ~clk;

    // Statistics buffers: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            avg_in   <= avg_mem[rd_addr];
            std_in   <= std_mem[rd_addr];
            gamma_in <= gam_mem[rd_addr];
            beta_in  <= bet_mem[rd_addr];
        end
    end

    // Calculator stand-in: a = gamma/std, b = beta - (gamma-avg)/std.
    always_comb begin
        cal_valid_out = cal_valid;
        cal_a = '0;
        cal_b = '0;
        if (cal_std != '0) begin
            cal_a = cal_gamma / cal_std;
            cal_b = cal_beta - (cal_gamma - cal_avg) / cal_std;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_valid && wr_ready && !abort) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d a %0d b %0d, expected none",
                         wr_addr, wr_a, wr_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_a", 64'(wr_a), 64'(e.a));
                chk("wr_b", 64'(wr_b), 64'(e.b));
            end
            wr_count++;
            last_addr = int'(wr_addr);
        end
        if (rst_n && done) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int av, input int sd, input int g, input int bt);
        avg_mem[i] = DW'(av);
        std_mem[i] = DW'(sd);
        gam_mem[i] = DW'(g);
        bet_mem[i] = DW'(bt);
    endtask

    task automatic push_exp(input int addr, input int a, input int b);
        exp_t e;
        e.addr = addr;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic start_pass(input int n);
        num_ch = CW'(n);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int k0, input int limit, output int k);
        k = k0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, wc0, dc0;
        for (int i = 0; i < MC; i++) set_ch(i, 0, 1, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({busy, done, zero_std_err, rd_en, cal_valid, wr_valid, rd_addr, wr_addr, cal_std, wr_a}),
            64'd0);
        rst_n = 1'b1;
        tick();

        // 1: three channels, ready tied high
        set_ch(0, 10, 2, 8, 1);
        set_ch(1, 20, 4, 8, 1);
        set_ch(2, 30, 5, 8, 1);
        push_exp(0, 4, 2);
        push_exp(1, 2, 4);
        push_exp(2, 1, 5);
        dc0 = done_count;
        start_pass(3);
        chk("t1_read_cycle1", 64'({busy, rd_en, rd_addr}), 64'({1'b1, 1'b1, 6'd0}));
        tick(); tick(); tick();
        chk("t1_wr_valid_cycle4", 64'({wr_valid, wr_addr}), 64'({1'b1, 6'd0}));
        wait_done(4, 40, k);
        chk("t1_done_cycle", 64'(k), 64'd13);
        chk("t1_zero_std_err", 64'(zero_std_err), 64'd0);
        tick();
        chk("t1_idle_busy", 64'({busy, done}), 64'd0);
        chk("t1_done_count", 64'(done_count - dc0), 64'd1);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: back-pressure on channel 0
        push_exp(0, 4, 2);
        push_exp(1, 2, 4);
        dc0 = done_count;
        wr_ready = 1'b0;
        start_pass(2);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_stable", 64'({wr_valid, wr_addr, wr_a, wr_b}),
                64'({1'b1, 6'd0, 16'sd4, 16'sd2}));
            tick();
        end
        wr_ready = 1'b1;
        chk("t2_accept_stable", 64'({wr_valid, wr_addr, wr_a, wr_b}),
            64'({1'b1, 6'd0, 16'sd4, 16'sd2}));
        tick();
        chk("t2_ch1_read", 64'({rd_en, rd_addr}), 64'({1'b1, 6'd1}));
        wait_done(10, 40, k);
        chk("t2_done_cycle", 64'(k), 64'd14);
        tick();
        chk("t2_done_count", 64'(done_count - dc0), 64'd1);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 3: zero std on channel 1
        set_ch(1, 0, 0, 6, 0);
        push_exp(0, 4, 2);
        push_exp(1, 6, -6);
        start_pass(2);
        repeat (6) tick();
        chk("t3_cal_std_subst", 64'({cal_valid, cal_std}), 64'({1'b1, 16'sd1}));
        wait_done(7, 40, k);
        chk("t3_done_cycle", 64'(k), 64'd9);
        chk("t3_zse_set", 64'(zero_std_err), 64'd1);
        tick(); tick();
        chk("t3_zse_sticky", 64'(zero_std_err), 64'd1);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4a: zero channels
        wc0 = wr_count;
        start_pass(0);
        chk("t4_zero_ch", 64'({done, busy, rd_en, wr_valid, zero_std_err}), 64'(5'b11000));
        tick();
        chk("t4_zero_ch_after", 64'({done, busy}), 64'd0);
        chk("t4_zero_ch_writes", 64'(wr_count - wc0), 64'd0);

        // 4b: oversize request clamps to MAX_CH
        for (int i = 0; i < MC; i++) begin
            set_ch(i, 0, 1, i, 0);
            push_exp(i, i, -i);
        end
        wc0 = wr_count;
        start_pass(100);
        wait_done(1, 400, k);
        chk("t4_clamp_done_cycle", 64'(k), 64'd257);
        tick();
        chk("t4_clamp_writes", 64'(wr_count - wc0), 64'd64);
        chk("t4_clamp_last_addr", 64'(last_addr), 64'd63);

        // 5: start while busy ignored; abort in WRITE of channel 1
        push_exp(0, 0, 0);
        wc0 = wr_count;
        dc0 = done_count;
        start_pass(4);
        tick();
        num_ch = CW'(1);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        chk("t5_in_write_ch1", 64'({wr_valid, wr_addr}), 64'({1'b1, 6'd1}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_idle", 64'({busy, wr_valid, rd_en, cal_valid, done}), 64'd0);
        repeat (3) tick();
        chk("t5_no_done", 64'(done_count - dc0), 64'd0);
        chk("t5_write_count", 64'(wr_count - wc0), 64'd1);
        abort  = 1'b1;
        start  = 1'b1;
        num_ch = CW'(1);
        tick();
        abort  = 1'b0;
        start  = 1'b0;
        chk("t5_abort_beats_start", 64'({busy, rd_en}), 64'd0);

        // 6: async reset mid-LOAD, then a clean single-channel pass
        set_ch(0, 10, 2, 8, 1);
        wc0 = wr_count;
        start_pass(2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset",
            64'({busy, done, zero_std_err, rd_en, cal_valid, wr_valid, rd_addr, wr_addr, cal_avg, wr_a}),
            64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_no_write", 64'(wr_count - wc0), 64'd0);
        push_exp(0, 4, 2);
        start_pass(1);
        wait_done(1, 20, k);
        chk("t6_done_cycle", 64'(k), 64'd5);
        tick();
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
